// File: rtl/axi_wb_pkg.sv
// Shared types for the AXI4-to-Wishbone burst bridge: burst/response encodings,
// the FSM state type and the response-merging helper.
package axi_wb_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_BUS,
    WR_RESP,
    RD_BUS,
    RD_DRAIN
  } state_t;

  // Encodings are ordered by severity, so the numerically larger one is the worse one.
  function automatic resp_t worst_resp(input resp_t a, input resp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding read beats; push while full is accepted only when a
// pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/axi4_to_wishbone_burst.sv
// AXI4 slave to Wishbone classic master bridge with INCR/FIXED/WRAP bursts,
// fair read/write arbitration, beat timeout and a read-data buffer.
// Valid/ready: a transfer happens on a rising edge where both are high; a VALID
// output is held with stable payload until its READY is seen.
module axi4_to_wishbone_burst
  import axi_wb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int RFIFO_DEPTH = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  output logic [ADDR_WIDTH-1:0]   wb_addr,
  output logic [DATA_WIDTH-1:0]   wb_wdata,
  output logic [DATA_WIDTH/8-1:0] wb_sel,
  input  logic [DATA_WIDTH-1:0]   wb_rdata,
  input  logic                    wb_ack,
  input  logic                    wb_err,
  output logic                    busy,
  output logic                    timeout_pulse,
  output logic [2:0]              state_dbg
);

  localparam int BYTES = DATA_WIDTH / 8;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d, beat_q, beat_d, pop_cnt_q, pop_cnt_d;
  burst_t                  burst_q, burst_d;
  resp_t                   bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BYTES-1:0]        wstrb_q, wstrb_d;
  logic                    lww_q, lww_d, cyc_hold_q, cyc_hold_d;
  logic [31:0]             tmo_q, tmo_d;

  logic                    tie, aw_win, rsvd, bus_phase, tmo_hit, beat_done, pop;
  resp_t                   beat_resp, push_resp;
  logic                    push, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0]   push_data;
  logic [DATA_WIDTH+1:0]   fifo_dout;
  logic [ADDR_WIDTH-1:0]   addr_inc, wrap_mask, addr_next;
  logic                    wrap_ok;

  always_comb begin
    addr_inc  = addr_q + ADDR_WIDTH'(BYTES);
    wrap_ok   = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
    wrap_mask = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) * ADDR_WIDTH'(BYTES) - ADDR_WIDTH'(1);
    addr_next = addr_inc;
    if (burst_q == BURST_FIXED) addr_next = addr_q;
    else if (burst_q == BURST_WRAP && wrap_ok)
      addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
  end

  // Bus-side beat control; the timeout cycle itself has STB/CYC low.
  always_comb begin
    rsvd      = (burst_q == BURST_RSVD);
    bus_phase = !rsvd && ((state_q == WR_BUS) || (state_q == RD_BUS && !fifo_full));
    tmo_hit   = bus_phase && (TIMEOUT != 0) && (tmo_q == 32'(TIMEOUT));
    wb_stb    = bus_phase && !tmo_hit;
    wb_cyc    = (wb_stb || cyc_hold_q) && !tmo_hit;
    beat_done = tmo_hit || (wb_stb && (wb_ack || wb_err));
    beat_resp = tmo_hit ? RESP_DECERR : (wb_err ? RESP_SLVERR : RESP_OKAY);
    tmo_d     = (bus_phase && !beat_done) ? tmo_q + 32'd1 : 32'd0;
    tie       = s_axi_awvalid && s_axi_arvalid;
    aw_win    = s_axi_awvalid && (!s_axi_arvalid || !lww_q);
    pop       = s_axi_rvalid && s_axi_rready;
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    pop_cnt_d  = pop_cnt_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    lww_d      = lww_q;
    cyc_hold_d = cyc_hold_q;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    push       = 1'b0;
    push_data  = '0;
    push_resp  = RESP_OKAY;
    case (state_q)
      IDLE: begin
        if (aw_win) begin
          s_axi_awready = 1'b1;
          id_d    = s_axi_awid;
          addr_d  = s_axi_awaddr;
          len_d   = s_axi_awlen;
          burst_d = burst_t'(s_axi_awburst);
          beat_d  = 8'd0;
          bresp_d = RESP_OKAY;
          state_d = WR_DATA;
          if (tie) lww_d = 1'b1;
        end else if (s_axi_arvalid) begin
          s_axi_arready = 1'b1;
          id_d      = s_axi_arid;
          addr_d    = s_axi_araddr;
          len_d     = s_axi_arlen;
          burst_d   = burst_t'(s_axi_arburst);
          beat_d    = 8'd0;
          pop_cnt_d = 8'd0;
          state_d   = RD_BUS;
          if (tie) lww_d = 1'b0;
        end
      end
      WR_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          wdata_d = s_axi_wdata;
          wstrb_d = s_axi_wstrb;
          if (s_axi_wlast != (beat_q == len_q)) bresp_d = worst_resp(bresp_q, RESP_SLVERR);
          state_d = WR_BUS;
        end
      end
      WR_BUS: begin
        if (rsvd || beat_done) begin
          bresp_d = worst_resp(bresp_q, rsvd ? RESP_SLVERR : beat_resp);
          addr_d  = addr_next;
          if (beat_q == len_q) begin
            state_d    = WR_RESP;
            cyc_hold_d = 1'b0;
          end else begin
            beat_d     = beat_q + 8'd1;
            state_d    = WR_DATA;
            cyc_hold_d = !rsvd && !tmo_hit;
          end
        end
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) state_d = IDLE;
      end
      RD_BUS: begin
        if (rsvd) begin
          push      = !fifo_full;
          push_resp = RESP_SLVERR;
        end else if (beat_done) begin
          push      = 1'b1;
          push_resp = beat_resp;
          push_data = tmo_hit ? '0 : wb_rdata;
        end
        if (push) begin
          addr_d = addr_next;
          if (beat_q == len_q) begin
            state_d    = RD_DRAIN;
            cyc_hold_d = 1'b0;
          end else begin
            beat_d     = beat_q + 8'd1;
            cyc_hold_d = !rsvd && !tmo_hit;
          end
        end
      end
      RD_DRAIN: ;
      default: state_d = IDLE;
    endcase
    if (pop) begin
      pop_cnt_d = pop_cnt_q + 8'd1;
      if (pop_cnt_q == len_q) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      burst_q    <= BURST_FIXED;
      beat_q     <= '0;
      pop_cnt_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      lww_q      <= 1'b0;
      cyc_hold_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      pop_cnt_q  <= pop_cnt_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      lww_q      <= lww_d;
      cyc_hold_q <= cyc_hold_d;
      tmo_q      <= tmo_d;
    end
  end

  sync_fifo #(.WIDTH(DATA_WIDTH + 2), .DEPTH(RFIFO_DEPTH)) u_rfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({push_data, 2'(push_resp)}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign s_axi_rvalid  = !fifo_empty;
  assign s_axi_rdata   = s_axi_rvalid ? fifo_dout[DATA_WIDTH+1:2] : '0;
  assign s_axi_rresp   = s_axi_rvalid ? fifo_dout[1:0] : 2'b00;
  assign s_axi_rlast   = s_axi_rvalid && (pop_cnt_q == len_q);
  assign s_axi_rid     = id_q;
  assign s_axi_bid     = id_q;
  assign s_axi_bresp   = bresp_q;
  assign wb_we         = (state_q == WR_BUS);
  assign wb_addr       = addr_q;
  assign wb_wdata      = wdata_q;
  assign wb_sel        = (state_q == RD_BUS) ? '1 : wstrb_q;
  assign busy          = (state_q != IDLE);
  assign timeout_pulse = tmo_hit;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_axi4_to_wishbone_burst.sv
// Scoreboard bench for the AXI4-to-Wishbone bridge: directed transactions push
// expected WB accesses, grants, B and R responses; monitors pop and compare.
module tb_axi4_to_wishbone_burst;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [1:0]  awburst = 2'b01, arburst = 2'b01, bresp, rresp;
  logic        awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic [3:0]  wstrb = 4'hF;
  logic        awready, arready, wready, bvalid, rvalid, rlast;
  logic        bready = 1'b1, rready = 1'b1;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err, busy, timeout_pulse;
  logic [31:0] wb_addr, wb_wdata, wb_rdata;
  logic [3:0]  wb_sel;
  logic [2:0]  state_dbg;

  logic        ack_en = 1'b1, err_arm = 1'b0;
  int          acc_cnt = 0, err_at = 0, cyc_cnt = 0;
  int          checks = 0, errors = 0;
  int          pulse_cnt = 0, stb_rise_cyc = 0;
  logic        stb_prev = 1'b0;

  logic [64:0] wb_exp_q[$];
  logic [38:0] r_exp_q[$];
  logic [5:0]  b_exp_q[$];
  logic [0:0]  g_exp_q[$];
  logic [64:0] wb_e;
  logic [38:0] r_e;
  logic [5:0]  b_e;
  logic [0:0]  g_e;

  assign wb_rdata = {16'hD000, wb_addr[15:0]};
  assign wb_err   = wb_stb && err_arm && (acc_cnt == err_at);
  assign wb_ack   = wb_stb && ack_en && !wb_err;

  axi4_to_wishbone_burst #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .RFIFO_DEPTH(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_wdata(wb_wdata), .wb_sel(wb_sel), .wb_rdata(wb_rdata),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .busy(busy), .timeout_pulse(timeout_pulse), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (wb_stb && (wb_ack || wb_err)) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got wait budget expired, required handshake", name);
  endtask

  // expectation helpers
  task automatic exp_wb(input logic we, input logic [31:0] a, input logic [31:0] d);
    wb_exp_q.push_back({we, a, d});
  endtask
  task automatic exp_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] rs, input logic l);
    r_exp_q.push_back({id, d, rs, l});
  endtask
  task automatic exp_b(input logic [3:0] id, input logic [1:0] rs);
    b_exp_q.push_back({id, rs});
  endtask
  task automatic exp_g(input logic is_read);
    g_exp_q.push_back(is_read);
  endtask

  // drivers
  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
    int n = 0;
    @(posedge clk); #1;
    awid = id; awaddr = a; awlen = l; awburst = b; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 300) begin @(negedge clk); n++; end
    if (!awready) flag("aw_handshake");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
    int n = 0;
    @(posedge clk); #1;
    arid = id; araddr = a; arlen = l; arburst = b; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 300) begin @(negedge clk); n++; end
    if (!arready) flag("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic l);
    int n = 0;
    @(posedge clk); #1;
    wdata = d; wlast = l; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 300) begin @(negedge clk); n++; end
    if (!wready) flag("w_handshake");
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic send_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                            input logic [1:0] b, input logic [31:0] d0, input int bad_idx);
    send_aw(id, a, l, b);
    for (int i = 0; i <= int'(l); i++)
      send_w(d0 + 32'(i), (i == int'(l)) ^ (i == bad_idx));
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while ((busy || wb_exp_q.size() != 0 || r_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 400) begin
      @(negedge clk); n++;
    end
    if (n >= 400) flag("transaction_drain");
  endtask

  // monitors
  always @(negedge clk) begin
    if (!rst && wb_stb && (wb_ack || wb_err)) begin
      if (wb_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: got access at 0x%0h, required none", wb_addr);
      end else begin
        wb_e = wb_exp_q.pop_front();
        check("wb_we", wb_we, wb_e[64]);
        check("wb_addr", wb_addr, wb_e[63:32]);
        if (wb_e[64]) check("wb_wdata", wb_wdata, wb_e[31:0]);
        else check("wb_sel_read", wb_sel, 4'hF);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rvalid && rready) begin
      if (r_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected: got R beat data 0x%0h, required none", rdata);
      end else begin
        r_e = r_exp_q.pop_front();
        check("r_id", rid, r_e[38:35]);
        check("r_data", rdata, r_e[34:3]);
        check("r_resp", rresp, r_e[2:1]);
        check("r_last", rlast, r_e[0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (b_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got B id 0x%0h resp 0x%0h, required none", bid, bresp);
      end else begin
        b_e = b_exp_q.pop_front();
        check("b_id", bid, b_e[5:2]);
        check("b_resp", bresp, b_e[1:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ((awvalid && awready) || (arvalid && arready))) begin
      if (g_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL grant_unexpected: got grant, required none");
      end else begin
        g_e = g_exp_q.pop_front();
        check("grant_is_read", arvalid && arready, g_e);
      end
    end
  end

  always @(negedge clk) begin
    if (wb_stb && !stb_prev) stb_rise_cyc = cyc_cnt;
    stb_prev = wb_stb;
    if (!rst && timeout_pulse) begin
      pulse_cnt++;
      check("tmo_latency", 32'(cyc_cnt - stb_rise_cyc), 32'd8);
      check("tmo_cyc_low", {wb_cyc, wb_stb}, 2'b00);
    end
  end

  // stimulus
  initial begin
    int acc0;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_wb_ctrl", {wb_cyc, wb_stb, wb_we}, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_tmo", timeout_pulse, 1'b0);
    check("rst_addr", wb_addr, 32'h0);
    check("rst_rdata", rdata, 32'h0);

    // INCR write, LEN=3
    exp_g(0);
    exp_wb(1, 32'h100, 32'hA0); exp_wb(1, 32'h104, 32'hA1);
    exp_wb(1, 32'h108, 32'hA2); exp_wb(1, 32'h10C, 32'hA3);
    exp_b(4'h3, 2'b00);
    send_write(4'h3, 32'h100, 8'd3, 2'b01, 32'hA0, -1);
    wait_done();

    // WRAP read with RREADY low for 10 cycles
    rready = 1'b0;
    exp_g(1);
    exp_wb(0, 32'h38, 0); exp_wb(0, 32'h3C, 0); exp_wb(0, 32'h30, 0); exp_wb(0, 32'h34, 0);
    exp_r(4'h1, 32'hD0000038, 2'b00, 0); exp_r(4'h1, 32'hD000003C, 2'b00, 0);
    exp_r(4'h1, 32'hD0000030, 2'b00, 0); exp_r(4'h1, 32'hD0000034, 2'b00, 1);
    acc0 = acc_cnt;
    send_ar(4'h1, 32'h38, 8'd3, 2'b10);
    repeat (10) @(negedge clk);
    check("wrap_accesses", 32'(acc_cnt - acc0), 32'd4);
    check("wrap_rvalid_held", rvalid, 1'b1);
    rready = 1'b1;
    wait_done();

    // INCR read LEN=7 with RREADY low: WB stalls once the buffer holds 4 beats
    rready = 1'b0;
    exp_g(1);
    for (int i = 0; i < 8; i++) begin
      exp_wb(0, 32'hF00 + 32'(4 * i), 0);
      exp_r(4'h2, 32'hD0000F00 + 32'(4 * i), 2'b00, i == 7);
    end
    acc0 = acc_cnt;
    send_ar(4'h2, 32'hF00, 8'd7, 2'b01);
    repeat (10) @(negedge clk);
    check("stall_accesses", 32'(acc_cnt - acc0), 32'd4);
    check("stall_stb_low", wb_stb, 1'b0);
    check("stall_cyc_held", wb_cyc, 1'b1);
    rready = 1'b1;
    wait_done();

    // tie 1: write wins
    exp_g(0); exp_g(1);
    exp_wb(1, 32'h400, 32'h55); exp_wb(0, 32'h500, 0);
    exp_b(4'h5, 2'b00); exp_r(4'h6, 32'hD0000500, 2'b00, 1);
    fork
      send_write(4'h5, 32'h400, 8'd0, 2'b01, 32'h55, -1);
      send_ar(4'h6, 32'h500, 8'd0, 2'b01);
    join
    wait_done();

    // tie 2: read wins
    exp_g(1); exp_g(0);
    exp_wb(0, 32'h600, 0); exp_wb(1, 32'h700, 32'h77);
    exp_r(4'h7, 32'hD0000600, 2'b00, 1); exp_b(4'h8, 2'b00);
    fork
      send_write(4'h8, 32'h700, 8'd0, 2'b01, 32'h77, -1);
      send_ar(4'h7, 32'h600, 8'd0, 2'b01);
    join
    wait_done();

    // ERR on beat 1 of a write, then of a read
    err_arm = 1'b1; err_at = acc_cnt + 1;
    exp_g(0);
    exp_wb(1, 32'h200, 32'h20); exp_wb(1, 32'h204, 32'h21); exp_wb(1, 32'h208, 32'h22);
    exp_b(4'h4, 2'b10);
    send_write(4'h4, 32'h200, 8'd2, 2'b01, 32'h20, -1);
    wait_done();
    err_at = acc_cnt + 1;
    exp_g(1);
    exp_wb(0, 32'h300, 0); exp_wb(0, 32'h304, 0); exp_wb(0, 32'h308, 0);
    exp_r(4'h4, 32'hD0000300, 2'b00, 0); exp_r(4'h4, 32'hD0000304, 2'b10, 0);
    exp_r(4'h4, 32'hD0000308, 2'b00, 1);
    send_ar(4'h4, 32'h300, 8'd2, 2'b01);
    wait_done();
    err_arm = 1'b0;

    // WLAST early on beat 0 of a LEN=1 write
    exp_g(0);
    exp_wb(1, 32'hB00, 32'h30); exp_wb(1, 32'hB04, 32'h31);
    exp_b(4'h9, 2'b10);
    send_write(4'h9, 32'hB00, 8'd1, 2'b01, 32'h30, 0);
    wait_done();

    // reserved burst: no WB access
    exp_g(0); exp_b(4'hA, 2'b10);
    send_write(4'hA, 32'hC00, 8'd0, 2'b11, 32'h40, -1);
    wait_done();
    exp_g(1);
    exp_r(4'hB, 32'h0, 2'b10, 0); exp_r(4'hB, 32'h0, 2'b10, 1);
    send_ar(4'hB, 32'hD00, 8'd1, 2'b11);
    wait_done();

    // FIXED write keeps the address
    exp_g(0);
    exp_wb(1, 32'hE00, 32'h11); exp_wb(1, 32'hE00, 32'h12);
    exp_b(4'h6, 2'b00);
    send_write(4'h6, 32'hE00, 8'd1, 2'b00, 32'h11, -1);
    wait_done();

    // timeout on a silent slave
    ack_en = 1'b0;
    exp_g(1); exp_r(4'hC, 32'h0, 2'b11, 1);
    send_ar(4'hC, 32'h800, 8'd0, 2'b01);
    wait_done();
    check("tmo_cyc_after", wb_cyc, 1'b0);
    check("tmo_pulse_count", 32'(pulse_cnt), 32'd1);
    ack_en = 1'b1;

    // reset during beat 2 of a LEN=7 write
    exp_g(0);
    exp_wb(1, 32'h900, 32'h60); exp_wb(1, 32'h904, 32'h61);
    acc0 = acc_cnt;
    send_aw(4'h2, 32'h900, 8'd7, 2'b01);
    send_w(32'h60, 1'b0);
    send_w(32'h61, 1'b0);
    n = 0;
    while (acc_cnt != acc0 + 2 && n < 50) begin @(negedge clk); n++; end
    if (acc_cnt != acc0 + 2) flag("rst_burst_progress");
    ack_en = 1'b0;
    send_w(32'h62, 1'b0);
    check("rst_beat2_stb", wb_stb, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_wb", {wb_cyc, wb_stb}, 2'b00);
    check("midrst_busy", busy, 1'b0);
    ack_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("midrst_no_bvalid", bvalid, 1'b0);
      @(negedge clk);
    end
    exp_g(0); exp_wb(1, 32'hA00, 32'h99); exp_b(4'h1, 2'b00);
    send_write(4'h1, 32'hA00, 8'd0, 2'b01, 32'h99, -1);
    wait_done();

    check("end_wb_queue", 32'(wb_exp_q.size()), 32'd0);
    check("end_grant_queue", 32'(g_exp_q.size()), 32'd0);
    check("end_pulse_count", 32'(pulse_cnt), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required finish");
    $fatal(1, "simulation time budget exceeded");
  end

endmodule
